fpu_issue_buffer: RTL and testbench

FPU_ISSUE_BUFFER -- requirements
Module: fpu_issue_buffer

---
 rtl/ibex_fp_pkg.sv | 45 ++++
 rtl/fpu_issue_fifo.sv | 78 +++++++
 rtl/fpu_issue_buffer.sv | 124 ++++++++++++
 tb/tb_fpu_issue_buffer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_fp_pkg.sv
// Shared FPU types for the issue path: opcode enum, issue-buffer entry and opcode helpers.
package ibex_fp_pkg;

    typedef enum logic [5:0] {
        FPU_NOP     = 6'd0,
        FPU_ADD     = 6'd1,
        FPU_SUB     = 6'd2,
        FPU_MUL     = 6'd3,
        FPU_DIV     = 6'd4,
        FPU_SQRT    = 6'd5,
        FPU_MADD    = 6'd6,
        FPU_MSUB    = 6'd7,
        FPU_NMADD   = 6'd8,
        FPU_NMSUB   = 6'd9,
        FPU_MIN     = 6'd10,
        FPU_MAX     = 6'd11,
        FPU_SGNJ    = 6'd12,
        FPU_CMP     = 6'd13,
        FPU_CVT_F2I = 6'd14,
        FPU_CVT_I2F = 6'd15,
        FPU_CLASS   = 6'd16
    } fpu_op_e;

    // Encodings at or above this count are not defined operations.
    localparam int unsigned FpuNumOps = 17;

    typedef struct packed {
        fpu_op_e     op;
        logic [2:0]  rm;
        logic [4:0]  tag;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } fpu_issue_entry_t;

    function automatic logic is_iter_op(fpu_op_e op);
        return (op == FPU_DIV) || (op == FPU_SQRT);
    endfunction

    // True for a defined, non-NOP opcode; anything else is dropped at the input.
    function automatic logic is_issuable(logic [5:0] op);
        return (op != FPU_NOP) && (32'(op) < FpuNumOps);
    endfunction

endpackage

// File: rtl/fpu_issue_fifo.sv
// Generic DEPTH-entry FIFO of FPU issue entries with synchronous flush.
module fpu_issue_fifo
    import ibex_fp_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  fpu_issue_entry_t wdata_i,
    input  logic             pop_i,
    output fpu_issue_entry_t rdata_o,
    output logic [CntW-1:0]  count_o,
    output logic             full_o,
    output logic             empty_o
);

    fpu_issue_entry_t mem_q [DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push_ok, pop_ok;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Power-of-two depth: pointer overflow is the modulo wrap.
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fpu_issue_buffer.sv
// Decode-to-FPU issue buffer that stalls behind iterative DIV/SQRT until the FPU reports done.
// Optional FPU_ISSUE_BYPASS_EN: zero-latency pass-through when the buffer is empty and idle.
module fpu_issue_buffer
    import ibex_fp_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [5:0]               in_op_i,
    input  logic [2:0]               in_rm_i,
    input  logic [4:0]               in_tag_i,
    input  logic [31:0]              in_a_i,
    input  logic [31:0]              in_b_i,
    input  logic [31:0]              in_c_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [5:0]               out_op_o,
    output logic [2:0]               out_rm_o,
    output logic [4:0]               out_tag_o,
    output logic [31:0]              out_a_o,
    output logic [31:0]              out_b_o,
    output logic [31:0]              out_c_o,
    output logic                     out_iter_o,
    input  logic                     iter_done_i,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     busy_o
);

    typedef enum logic [0:0] {StIssue, StWaitIter} state_e;

    state_e state_q, state_d;

    fpu_issue_entry_t in_entry, head_entry, out_entry;
    logic             op_ok;
    logic             accept, bypass, head_valid, issue;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;

    assign op_ok    = is_issuable(in_op_i);
    assign in_entry = '{
        op:  op_ok ? fpu_op_e'(in_op_i) : FPU_NOP,
        rm:  in_rm_i,
        tag: in_tag_i,
        a:   in_a_i,
        b:   in_b_i,
        c:   in_c_i
    };

    assign in_ready_o = !fifo_full && !flush_i;
    assign accept     = in_valid_i && in_ready_o;
    assign head_valid = !fifo_empty && (state_q == StIssue) && !flush_i;

`ifdef FPU_ISSUE_BYPASS_EN
    assign bypass    = fifo_empty && (state_q == StIssue) && in_valid_i && out_ready_i && op_ok &&
                       !flush_i;
    assign out_entry = bypass ? in_entry : head_entry;
`else
    assign bypass    = 1'b0;
    assign out_entry = head_entry;
`endif

    assign out_valid_o = head_valid || bypass;
    assign issue       = out_valid_o && out_ready_i;
    // Bypassed ops never touch storage: no write and no pop.
    assign fifo_push   = accept && op_ok && !bypass;
    assign fifo_pop    = issue && !bypass;

    fpu_issue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (fifo_push),
        .wdata_i (in_entry),
        .pop_i   (fifo_pop),
        .rdata_o (head_entry),
        .count_o (count_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out_op_o   = out_entry.op;
    assign out_rm_o   = out_entry.rm;
    assign out_tag_o  = out_entry.tag;
    assign out_a_o    = out_entry.a;
    assign out_b_o    = out_entry.b;
    assign out_c_o    = out_entry.c;
    assign out_iter_o = is_iter_op(out_entry.op);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIssue: begin
                if (issue && out_iter_o) begin
                    state_d = StWaitIter;
                end
            end
            StWaitIter: begin
                if (iter_done_i) begin
                    state_d = StIssue;
                end
            end
            default: state_d = StIssue;
        endcase
        if (flush_i) begin
            state_d = StIssue;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIssue;
        end else begin
            state_q <= state_d;
        end
    end

    assign busy_o = (state_q == StWaitIter);

endmodule

// File: tb/tb_fpu_issue_buffer.sv
// Self-checking bench: queue-based reference model checked every cycle plus directed literal checks.
module tb_fpu_issue_buffer;

    localparam int DEPTH = 4;
    localparam int NUM_OPS = 17;
    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd2;
    localparam logic [5:0] OP_MUL  = 6'd3;
    localparam logic [5:0] OP_DIV  = 6'd4;
    localparam logic [5:0] OP_SQRT = 6'd5;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [5:0]  in_op;
    logic [2:0]  in_rm;
    logic [4:0]  in_tag;
    logic [31:0] in_a, in_b, in_c;
    logic        out_valid, out_ready;
    logic [5:0]  out_op;
    logic [2:0]  out_rm;
    logic [4:0]  out_tag;
    logic [31:0] out_a, out_b, out_c;
    logic        out_iter, iter_done, flush, busy;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fpu_issue_buffer #(
        .DEPTH (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_op_i     (in_op),
        .in_rm_i     (in_rm),
        .in_tag_i    (in_tag),
        .in_a_i      (in_a),
        .in_b_i      (in_b),
        .in_c_i      (in_c),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_op_o    (out_op),
        .out_rm_o    (out_rm),
        .out_tag_o   (out_tag),
        .out_a_o     (out_a),
        .out_b_o     (out_b),
        .out_c_o     (out_c),
        .out_iter_o  (out_iter),
        .iter_done_i (iter_done),
        .flush_i     (flush),
        .count_o     (count),
        .busy_o      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [2:0]  rm;
        logic [4:0]  tag;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } ent_t;

    ent_t mq[$];
    bit   m_wait;

    function automatic bit m_valid_op(logic [5:0] op);
        return (op != OP_NOP) && (int'(op) < NUM_OPS);
    endfunction

    function automatic bit m_iter(logic [5:0] op);
        return (op == OP_DIV) || (op == OP_SQRT);
    endfunction

    // Reference model: checks outputs mid-cycle, then advances to the post-edge state.
    always @(negedge clk) begin : model
        ent_t inent, issued;
        bit   byp, exp_valid, exp_ready, did_issue;
        if (rst) begin
            mq.delete();
            m_wait = 1'b0;
            chk("rst_count", 32'(count), 32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            chk("rst_busy", 32'(busy), 32'd0);
        end else begin
            inent = '{op: in_op, rm: in_rm, tag: in_tag, a: in_a, b: in_b, c: in_c};
            exp_ready = (mq.size() < DEPTH) && !flush;
            byp = 1'b0;
`ifdef FPU_ISSUE_BYPASS_EN
            byp = (mq.size() == 0) && !m_wait && in_valid && out_ready && m_valid_op(in_op) && !flush;
`endif
            exp_valid = byp || ((mq.size() > 0) && !m_wait && !flush);
            chk("m_count", 32'(count), 32'(mq.size()));
            chk("m_in_ready", 32'(in_ready), 32'(exp_ready));
            chk("m_out_valid", 32'(out_valid), 32'(exp_valid));
            chk("m_busy", 32'(busy), 32'(m_wait));
            issued = byp ? inent : (mq.size() > 0 ? mq[0] : inent);
            if (exp_valid) begin
                chk("m_op", 32'(out_op), 32'(issued.op));
                chk("m_rm", 32'(out_rm), 32'(issued.rm));
                chk("m_tag", 32'(out_tag), 32'(issued.tag));
                chk("m_a", out_a, issued.a);
                chk("m_b", out_b, issued.b);
                chk("m_c", out_c, issued.c);
                chk("m_iter", 32'(out_iter), 32'(m_iter(issued.op)));
            end
            if (flush) begin
                mq.delete();
                m_wait = 1'b0;
            end else begin
                did_issue = exp_valid && out_ready;
                if (did_issue && !byp) void'(mq.pop_front());
                if (did_issue && m_iter(issued.op)) m_wait = 1'b1;
                else if (m_wait && iter_done) m_wait = 1'b0;
                if (in_valid && exp_ready && m_valid_op(in_op) && !byp) mq.push_back(inent);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [4:0] tag, input logic [31:0] a,
                         input logic [31:0] b);
        in_valid = 1'b1;
        in_op    = op;
        in_tag   = tag;
        in_rm    = tag[2:0];
        in_a     = a;
        in_b     = b;
        in_c     = a ^ b;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_rm = '0; in_tag = '0;
        in_a = '0; in_b = '0; in_c = '0; out_ready = 1'b0; iter_done = 1'b0; flush = 1'b0;
        step(); step();
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk("rel_count", 32'(count), 32'd0);

        // Single ADD round trip
        out_ready = 1'b1;
        drive(OP_ADD, 5'd3, 32'h3F800000, 32'h40000000);
`ifdef FPU_ISSUE_BYPASS_EN
        #1;
        chk("t1_byp_valid", 32'(out_valid), 32'd1);
        chk("t1_byp_count", 32'(count), 32'd0);
        step(); idle();
`else
        step(); idle();
        #1;
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_op", 32'(out_op), 32'd1);
        chk("t1_a", out_a, 32'h3F800000);
        chk("t1_b", out_b, 32'h40000000);
        chk("t1_tag", 32'(out_tag), 32'd3);
        chk("t1_count", 32'(count), 32'd1);
        step();
        #1;
        chk("t1_drain_count", 32'(count), 32'd0);
        chk("t1_drain_valid", 32'(out_valid), 32'd0);
`endif

        // Fill, hold the 5th push, then pop/push across the pointer wrap
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(OP_MUL, 5'(10 + i), 32'(100 + i), 32'(200 + i));
            step();
        end
        drive(OP_MUL, 5'd14, 32'd104, 32'd204);
        #1;
        chk("t2_full_count", 32'(count), 32'd4);
        chk("t2_full_ready", 32'(in_ready), 32'd0);
        step();
        #1;
        chk("t2_held_count", 32'(count), 32'd4);
        out_ready = 1'b1;
        step();
        #1;
        chk("t2_popblk_count", 32'(count), 32'd3);
        chk("t2_popblk_tag", 32'(out_tag), 32'd11);
        step(); idle();
        #1;
        chk("t2_pp_count", 32'(count), 32'd3);
        chk("t2_pp_tag", 32'(out_tag), 32'd12);
        out_ready = 1'b0;
        drive(OP_MUL, 5'd15, 32'd105, 32'd205);
        step(); idle();
        #1;
        chk("t2_refill_count", 32'(count), 32'd4);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        #1;
        chk("t2_empty_count", 32'(count), 32'd0);

        // DIV stalls the following MUL until iter_done
        drive(OP_DIV, 5'd1, 32'h40800000, 32'h40000000);
        step();
        drive(OP_MUL, 5'd2, 32'h3F800000, 32'h3F800000);
`ifndef FPU_ISSUE_BYPASS_EN
        #1;
        chk("t3_iter", 32'(out_iter), 32'd1);
`endif
        step(); idle();
        #1;
        chk("t3_busy", 32'(busy), 32'd1);
        chk("t3_stall_valid", 32'(out_valid), 32'd0);
        chk("t3_count", 32'(count), 32'd1);
        step(); step();
        #1;
        chk("t3_still_busy", 32'(busy), 32'd1);
        iter_done = 1'b1;
        #1;
        chk("t3_done_valid", 32'(out_valid), 32'd0);
        step();
        iter_done = 1'b0;
        #1;
        chk("t3_resume_busy", 32'(busy), 32'd0);
        chk("t3_resume_valid", 32'(out_valid), 32'd1);
        chk("t3_resume_op", 32'(out_op), 32'd3);
        chk("t3_resume_tag", 32'(out_tag), 32'd2);
        step();
        #1;
        chk("t3_drain_count", 32'(count), 32'd0);

        // Flush beats a simultaneous push
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(OP_ADD, 5'(20 + i), 32'(300 + i), 32'(400 + i));
            step();
        end
        drive(OP_ADD, 5'd23, 32'd303, 32'd403);
        flush = 1'b1;
        #1;
        chk("t4_flush_ready", 32'(in_ready), 32'd0);
        chk("t4_flush_valid", 32'(out_valid), 32'd0);
        step();
        flush = 1'b0; idle();
        #1;
        chk("t4_count", 32'(count), 32'd0);
        chk("t4_valid", 32'(out_valid), 32'd0);

        // NOP and out-of-range opcodes complete the handshake but are dropped
        out_ready = 1'b1;
        drive(OP_NOP, 5'd5, 32'd1, 32'd2);
        #1;
        chk("t5_nop_ready", 32'(in_ready), 32'd1);
        step();
        drive(6'd40, 5'd6, 32'd3, 32'd4);
        step(); idle();
        #1;
        chk("t5_nop_count", 32'(count), 32'd0);
        chk("t5_nop_valid", 32'(out_valid), 32'd0);

        // iter_done in ISSUE has no effect
        iter_done = 1'b1;
        step();
        iter_done = 1'b0;

        // Reset in the middle of WAIT_ITER
        drive(OP_SQRT, 5'd7, 32'h41100000, 32'd0);
        step(); idle();
        for (int k = 0; k < 5 && !busy; k++) step();
        chk("t5_wait_reached", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_ready", 32'(in_ready), 32'd1);
        chk("t5_rst_count", 32'(count), 32'd0);
        step();
        rst = 1'b0;
        step();

`ifdef FPU_ISSUE_BYPASS_EN
        // Zero-latency pass-through
        out_ready = 1'b1;
        drive(OP_SUB, 5'd9, 32'h40400000, 32'h3F800000);
        #1;
        chk("t6_byp_valid", 32'(out_valid), 32'd1);
        chk("t6_byp_op", 32'(out_op), 32'd2);
        chk("t6_byp_count", 32'(count), 32'd0);
        step(); idle();
        #1;
        chk("t6_after_count", 32'(count), 32'd0);
        chk("t6_after_valid", 32'(out_valid), 32'd0);
`endif

        // Mixed traffic, checked by the model every cycle
        for (int i = 0; i < 80; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_op     = 6'($urandom_range(0, 20));
            in_tag    = 5'($urandom_range(0, 31));
            in_rm     = 3'($urandom_range(0, 7));
            in_a      = $urandom;
            in_b      = $urandom;
            in_c      = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            iter_done = ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            step();
        end
        idle();
        flush = 1'b0;
        iter_done = 1'b0;
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
